// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: byte request handshake bundle between NREQ producers and the UART scheduler
// Signals:
//   req_valid [NREQ]   per-requester byte available (producer -> scheduler)
//   req_data  [8*NREQ] byte for requester i in bits [8i+7:8i] (producer -> scheduler)
//   req_ready [NREQ]   one-hot accept; transfer when valid & ready in the same cycle
// Modports: master = producer side, slave = scheduler side.
interface uart_tx_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;

    modport master (output req_valid, output req_data, input req_ready);
    modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one 8N1 UART TX line between NREQ byte requesters
// Ports:
//   clk       system clock, all state on rising edge
//   rst       asynchronous active-high reset
//   bus       request handshake (slave modport): req_valid, req_data, req_ready
//   grant_id  index of requester whose frame is on the line / last granted
//   busy      high from start bit through stop bit
//   tx_done   one-cycle pulse on the last clock of the stop bit
//   tx        serial line, idle high
module uart_tx_sched #(
    parameter int NREQ = 4,
    parameter int DIV  = 16,
    parameter int CW   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_tx_sched_if.slave        bus,
    output logic [2:0]            grant_id,
    output logic                  busy,
    output logic                  tx_done,
    output logic                  tx
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic [2:0]      ptr;
    logic            found;
    logic [2:0]      sel;
    logic [7:0]      sel_data;
    logic [3:0]      idx;
    logic [NREQ-1:0] ready_v;
    logic            last;

    assign last = cnt == CW'(DIV - 1);
    assign bus.req_ready = ready_v;

    // Search from ptr upward with wrap; the inner loop maps the rotated index
    // back to a constant requester number so no variable-width bit select is needed.
    always_comb begin
        found = 1'b0;
        sel = '0;
        sel_data = '0;
        idx = '0;
        ready_v = '0;
        for (int j = 0; j < NREQ; j++) begin
            idx = 4'(ptr) + 4'(j);
            if (idx >= 4'(NREQ)) idx = idx - 4'(NREQ);
            for (int k = 0; k < NREQ; k++)
                if (!found && idx == 4'(k) && bus.req_valid[k]) begin
                    found = 1'b1;
                    sel = 3'(k);
                end
        end
        for (int k = 0; k < NREQ; k++) begin
            ready_v[k] = found && sel == 3'(k) && state == IDLE && !rst;
            if (sel == 3'(k)) sel_data = bus.req_data[8*k +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            ptr      <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
            tx       <= 1'b1;
        end else begin
            cnt <= (state == IDLE || last) ? '0 : cnt + CW'(1);
            case (state)
                IDLE: begin
                    tx      <= 1'b1;
                    busy    <= 1'b0;
                    tx_done <= 1'b0;
                    if (found) begin
                        shift    <= sel_data;
                        grant_id <= sel;
                        ptr      <= (sel == 3'(NREQ - 1)) ? 3'd0 : sel + 3'd1;
                        state    <= START;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                START: if (last) begin
                    state   <= DATA;
                    bit_idx <= '0;
                    tx      <= shift[0];
                end
                DATA: if (last) begin
                    if (bit_idx == 3'd7) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end else begin
                        shift   <= shift >> 1;
                        tx      <= shift[1];
                        bit_idx <= bit_idx + 3'd1;
                    end
                end
                STOP: begin
                    // Registered, so raise it one clock early to land on the final stop clock.
                    tx_done <= cnt == CW'(DIV - 2);
                    if (last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
